// File: rtl/dwrr_req_queues.sv
// Per-flow request FIFOs in front of a DWRR arbiter: each non-empty queue raises a request, and the granted head word is popped into a registered output.
// Optional macro DWRR_GNT_CHECK_EN builds a sticky grant-protocol checker on err.

module dwrr_req_fifo #(
  parameter int DWID  = 8,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [DWID-1:0] din_i,
  output logic [DWID-1:0] head_o,
  output logic            ready_o,
  output logic            nempty_o
);
  logic [DWID-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign ready_o  = (cnt_q != (PW+1)'(DEPTH));
  assign nempty_o = (cnt_q != '0);
  assign head_o   = mem_q[rd_ptr_q];

  // Readiness comes from the registered count, so a full queue refuses a push even when it is popped in the same cycle.
  assign do_push = push_i & ready_o;
  assign do_pop  = pop_i & nempty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

module dwrr_req_queues #(
  parameter int NUM_REQS = 4,
  parameter int DWID     = 8,
  parameter int DEPTH    = 4,
  parameter int CNTWID   = $clog2(NUM_REQS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQS-1:0]      in_valid,
  input  logic [NUM_REQS*DWID-1:0] in_data,
  output logic [NUM_REQS-1:0]      in_ready,
  output logic [NUM_REQS-1:0]      reqs,
  input  logic [NUM_REQS-1:0]      gnt,
  output logic                     out_valid,
  output logic [DWID-1:0]          out_data,
  output logic [CNTWID-1:0]        out_id,
  output logic                     err
);
  logic [NUM_REQS-1:0][DWID-1:0] head;
  logic [NUM_REQS-1:0]           pop_vec;
  logic [CNTWID-1:0]             pop_id;
  logic                          pop_any;
  logic                          out_valid_q;
  logic [DWID-1:0]               out_data_q, out_data_d;
  logic [CNTWID-1:0]             out_id_q, out_id_d;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_q
    dwrr_req_fifo #(.DWID(DWID), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (in_valid[g]),
      .pop_i    (pop_vec[g]),
      .din_i    (in_data[g*DWID +: DWID]),
      .head_o   (head[g]),
      .ready_o  (in_ready[g]),
      .nempty_o (reqs[g])
    );
  end

  // Descending scan so the lowest-index granted non-empty queue wins a multi-hot grant.
  always_comb begin
    pop_vec = '0;
    pop_id  = '0;
    pop_any = 1'b0;
    for (int i = NUM_REQS-1; i >= 0; i--) begin
      if (gnt[i] && reqs[i]) begin
        pop_any = 1'b1;
        pop_id  = CNTWID'(i);
      end
    end
    if (pop_any) pop_vec[pop_id] = 1'b1;
  end

  always_comb begin
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    if (pop_any) begin
      out_data_d = head[pop_id];
      out_id_d   = pop_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      out_valid_q <= pop_any;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

`ifdef DWRR_GNT_CHECK_EN
  logic err_q;
  logic gnt_bad;
  // Violations: granting an idle requestor, or more than one grant bit set.
  assign gnt_bad = ((gnt & ~reqs) != '0) || ((gnt & (gnt - NUM_REQS'(1))) != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_q <= 1'b0;
    else if (gnt_bad) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_dwrr_req_queues.sv
// Directed bench for dwrr_req_queues: FIFO order, full/empty edges, grant filtering, a DWRR closed loop and mid-stream reset.
module tb_dwrr_req_queues;
  localparam int NR = 4, DW = 8, DP = 4, CW = 2;
`ifdef DWRR_GNT_CHECK_EN
  localparam logic GCHK = 1'b1;
`else
  localparam logic GCHK = 1'b0;
`endif

  logic              clk, rst;
  logic [NR-1:0]     in_valid, in_ready, reqs, gnt;
  logic [NR*DW-1:0]  in_data;
  logic              out_valid, err;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_id;

  int n_chk = 0;
  int n_fail = 0;

  dwrr_req_queues #(.NUM_REQS(NR), .DWID(DW), .DEPTH(DP), .CNTWID(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reqs(reqs), .gnt(gnt), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int q, input logic [DW-1:0] w);
    in_data[q*DW +: DW] = w;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = '0; gnt = '0; in_data = '0;
    tick(); tick();
    rst = 1'b1;
  endtask

  // DWRR model state for the closed loop
  int def_cnt [NR];
  int exp_idx [NR];
  int cur, delivered, cyc, gq;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_reqs", reqs, 4'h0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_err", err, 0);

    // Two words through queue 2
    in_valid = 4'b0100; set_word(2, 8'hA1); tick();
    set_word(2, 8'hA2); tick();
    in_valid = '0;
    chk("q2_reqs", reqs, 4'b0100);
    gnt = 4'b0100; tick();
    chk("q2_pop1_v", out_valid, 1);
    chk("q2_pop1_d", out_data, 8'hA1);
    chk("q2_pop1_id", out_id, 2);
    chk("q2_reqs_mid", reqs, 4'b0100);
    tick();
    chk("q2_pop2_v", out_valid, 1);
    chk("q2_pop2_d", out_data, 8'hA2);
    chk("q2_reqs_empty", reqs, 4'b0000);
    gnt = '0; tick();
    chk("q2_idle_v", out_valid, 0);
    chk("q2_hold_d", out_data, 8'hA2);
    chk("q2_hold_id", out_id, 2);

    // Fill queue 0, overflow push dropped, push during pop while full dropped
    in_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_word(0, 8'h10 + 8'(k)); tick();
    end
    chk("q0_full", in_ready, 4'b1110);
    set_word(0, 8'h14); tick();
    chk("q0_full_drop", in_ready, 4'b1110);
    set_word(0, 8'h15); gnt = 4'b0001; tick();
    in_valid = '0;
    chk("q0_pp_d", out_data, 8'h10);
    chk("q0_pp_ready", in_ready, 4'hF);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("q0_drain", out_data, 8'h10 + 8'(k));
    end
    chk("q0_empty", reqs, 4'b0000);
    gnt = '0; tick();
    chk("q0_no_extra", out_valid, 0);

    // Eight words through queue 1, pushes overlapping pops; pointers wrap twice
    in_valid = 4'b0010; set_word(1, 8'h30); tick();
    gnt = 4'b0010;
    for (int k = 1; k < 8; k++) begin
      set_word(1, 8'h30 + 8'(k)); tick();
      chk("q1_order", out_data, 8'h30 + 8'(k - 1));
      chk("q1_id", out_id, 1);
      chk("q1_cnt1", reqs, 4'b0010);
    end
    in_valid = '0; tick();
    chk("q1_last", out_data, 8'h37);
    chk("q1_empty", reqs, 4'b0000);
    chk("q1_ready", in_ready, 4'hF);
    gnt = '0; tick();

    // Grant to empty queue 3
    gnt = 4'b1000; tick();
    chk("g3_nopop", out_valid, 0);
    chk("g3_err", err, GCHK);
    gnt = '0; tick();
    chk("g3_err_hold", err, GCHK);

    // Multi-hot grant: lowest non-empty wins
    in_valid = 4'b0101; set_word(0, 8'h50); set_word(2, 8'h52); tick();
    in_valid = '0; gnt = 4'b0101; tick();
    gnt = '0;
    chk("mh_v", out_valid, 1);
    chk("mh_id", out_id, 0);
    chk("mh_d", out_data, 8'h50);
    chk("mh_reqs", reqs, 4'b0100);
    chk("mh_err", err, GCHK);
    gnt = 4'b0100; tick();
    gnt = '0;
    chk("mh_q2_d", out_data, 8'h52);
    tick();

    // Closed loop with a DWRR grant model (quantum 16, packet size 8)
    do_reset();
    chk("rst2_err", err, 0);
    in_valid = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      for (int q = 0; q < NR; q++) set_word(q, 8'h60 + 8'(q * 16 + k));
      tick();
    end
    in_valid = '0;
    for (int q = 0; q < NR; q++) begin def_cnt[q] = 0; exp_idx[q] = 0; end
    cur = 0; def_cnt[0] = 16; delivered = 0; cyc = 0;
    while (delivered < 12 && cyc < 300) begin
      gq = -1;
      if (reqs[cur] && def_cnt[cur] >= 8) begin
        gq = cur; def_cnt[cur] -= 8; gnt = 4'(1 << cur);
      end else begin
        if (!reqs[cur]) def_cnt[cur] = 0;
        cur = (cur + 1) % NR; def_cnt[cur] += 16; gnt = '0;
      end
      tick();
      cyc++;
      if (gq >= 0) begin
        chk("cl_v", out_valid, 1);
        chk("cl_id", out_id, gq);
        chk("cl_d", out_data, 8'h60 + 8'(gq * 16 + exp_idx[gq]));
        exp_idx[gq]++;
        delivered++;
      end
    end
    gnt = '0;
    chk("cl_count", delivered, 12);
    chk("cl_err", err, 0);
    chk("cl_reqs", reqs, 4'b0000);

    // Reset in the middle of traffic
    in_valid = 4'b0100; set_word(2, 8'h90); tick(); set_word(2, 8'h91); tick();
    in_valid = '0; gnt = 4'b0100; tick();
    chk("mr_pre_v", out_valid, 1);
    #2 rst = 1'b0; gnt = '0;
    #1;
    chk("mr_reqs", reqs, 4'b0000);
    chk("mr_v", out_valid, 0);
    chk("mr_d", out_data, 0);
    chk("mr_ready", in_ready, 4'hF);
    rst = 1'b1; in_valid = 4'b0010; set_word(1, 8'h77); tick();
    in_valid = '0;
    chk("mr_after_reqs", reqs, 4'b0010);
    chk("mr_after_v", out_valid, 0);
    gnt = 4'b0010; tick();
    gnt = '0;
    chk("mr_after_d", out_data, 8'h77);
    chk("mr_after_id", out_id, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
